// File: rtl/plab2_proc_rf_wb_arbiter_if.sv
// Write-port bus between the W stage / mul-div unit and the regfile write arbiter.
// The master side drives requests and scoreboard allocations; the slave side is the arbiter.
interface plab2_proc_rf_wb_arbiter_if #(
  parameter int unsigned p_data_nbits = 32,
  parameter int unsigned p_addr_nbits = 5,
  parameter int unsigned p_num_regs   = 32
);
  logic                    req0_val;
  logic                    req0_rdy;
  logic [p_addr_nbits-1:0] req0_addr;
  logic [p_data_nbits-1:0] req0_data;
  logic                    req1_val;
  logic                    req1_rdy;
  logic [p_addr_nbits-1:0] req1_addr;
  logic [p_data_nbits-1:0] req1_data;
  logic                    write_en;
  logic [p_addr_nbits-1:0] write_addr;
  logic [p_data_nbits-1:0] write_data;
  logic                    alloc_val;
  logic [p_addr_nbits-1:0] alloc_addr;
  logic [p_num_regs-1:0]   busy;

  modport master (
    output req0_val, req0_addr, req0_data,
    output req1_val, req1_addr, req1_data,
    output alloc_val, alloc_addr,
    input  req0_rdy, req1_rdy,
    input  write_en, write_addr, write_data, busy
  );

  modport slave (
    input  req0_val, req0_addr, req0_data,
    input  req1_val, req1_addr, req1_data,
    input  alloc_val, alloc_addr,
    output req0_rdy, req1_rdy,
    output write_en, write_addr, write_data, busy
  );
endinterface

// File: rtl/plab2_proc_rf_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port (req0 = W stage, req1 = mul/div).
// Optional pending-write scoreboard enabled by PLAB2_PROC_RF_WB_SCOREBOARD_EN.
module plab2_proc_rf_wb_arbiter #(
  parameter int unsigned p_data_nbits = 32,
  parameter int unsigned p_addr_nbits = 5,
  parameter int unsigned p_num_regs   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  plab2_proc_rf_wb_arbiter_if.slave  bus
);
  localparam int unsigned DW = p_data_nbits;
  localparam int unsigned AW = p_addr_nbits;
  localparam int unsigned NR = p_num_regs;

  localparam logic [0:0] PRIO_REQ0 = 1'b0;
  localparam logic [0:0] PRIO_REQ1 = 1'b1;

  logic [0:0]    prio_q, prio_d;
  logic          write_en_q, write_en_d;
  logic [AW-1:0] write_addr_q, write_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic          grant0_c, grant1_c;

  // Grants are held off while reset is asserted so no request slips through.
  always_comb begin
    grant0_c = bus.req0_val & reset & (~bus.req1_val | (prio_q == PRIO_REQ0));
    grant1_c = bus.req1_val & reset & (~bus.req0_val | (prio_q == PRIO_REQ1));
  end

  assign bus.req0_rdy = grant0_c;
  assign bus.req1_rdy = grant1_c;

  always_comb begin
    prio_d       = prio_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant0_c) begin
      prio_d       = PRIO_REQ1;
      write_en_d   = (bus.req0_addr != AW'(0));
      write_addr_d = bus.req0_addr;
      write_data_d = bus.req0_data;
    end else if (grant1_c) begin
      prio_d       = PRIO_REQ0;
      write_en_d   = (bus.req1_addr != AW'(0));
      write_addr_d = bus.req1_addr;
      write_data_d = bus.req1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= PRIO_REQ0;
      write_en_q   <= 1'b0;
      write_addr_q <= AW'(0);
      write_data_q <= DW'(0);
    end else begin
      prio_q       <= prio_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;

`ifdef PLAB2_PROC_RF_WB_SCOREBOARD_EN
  logic [NR-1:0] busy_q, busy_d;

  // Clear on mul/div writeback, then set on allocation so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (grant1_c && (bus.req1_addr != AW'(0))) begin
      busy_d[bus.req1_addr] = 1'b0;
    end
    if (bus.alloc_val && (bus.alloc_addr != AW'(0))) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= NR'(0);
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy = busy_q;
`else
  logic alloc_unused;

  assign alloc_unused = ^{bus.alloc_val, bus.alloc_addr};
  assign bus.busy     = NR'(0);
`endif
endmodule

// File: tb/tb_plab2_proc_rf_wb_arbiter.sv
// Scoreboard bench for the regfile write-port arbiter: directed cases then random traffic.
module tb_plab2_proc_rf_wb_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab2_proc_rf_wb_arbiter_if #(.p_data_nbits(DW), .p_addr_nbits(AW), .p_num_regs(NR)) rf_if ();

  plab2_proc_rf_wb_arbiter #(.p_data_nbits(DW), .p_addr_nbits(AW), .p_num_regs(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            zero;
    longint        due;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  longint        cyc = 0;
  int            turn = 0;
  logic [NR-1:0] exp_busy = '0;
  bit            hold_known = 1'b1;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle the write port either carries the oldest due write or is idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.zero) begin
        check("write_en_r0", 64'(rf_if.write_en), 64'(0));
        hold_known = 1'b0;
      end else begin
        check("write_en", 64'(rf_if.write_en), 64'(1));
        check("write_addr", 64'(rf_if.write_addr), 64'(e.addr));
        check("write_data", 64'(rf_if.write_data), 64'(e.data));
        last_addr  = e.addr;
        last_data  = e.data;
        hold_known = 1'b1;
      end
    end else begin
      check("write_en_idle", 64'(rf_if.write_en), 64'(0));
      if (hold_known) begin
        check("write_addr_hold", 64'(rf_if.write_addr), 64'(last_addr));
        check("write_data_hold", 64'(rf_if.write_data), 64'(last_data));
      end
    end
  end

  // One clock of stimulus; the reference model decides grants and queues the expected write.
  task automatic do_cycle(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input bit av, input logic [AW-1:0] aa,
                          output bit g0, output bit g1);
    exp_t e;
    rf_if.req0_val   = v0;
    rf_if.req0_addr  = a0;
    rf_if.req0_data  = d0;
    rf_if.req1_val   = v1;
    rf_if.req1_addr  = a1;
    rf_if.req1_data  = d1;
    rf_if.alloc_val  = av;
    rf_if.alloc_addr = aa;
    @(negedge clk);
    check("busy", 64'(rf_if.busy), 64'(exp_busy));
    if (v0 && v1) begin
      g0 = (turn == 0);
      g1 = !g0;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    check("req0_rdy", 64'(rf_if.req0_rdy), 64'(g0));
    check("req1_rdy", 64'(rf_if.req1_rdy), 64'(g1));
    if (g0 || g1) begin
      turn   = g0 ? 1 : 0;
      e.addr = g0 ? a0 : a1;
      e.data = g0 ? d0 : d1;
      e.zero = (e.addr == '0);
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
`ifdef PLAB2_PROC_RF_WB_SCOREBOARD_EN
    if (g1 && a1 != '0) exp_busy[a1] = 1'b0;
    if (av && aa != '0) exp_busy[aa] = 1'b1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit g0, g1;
    for (int i = 0; i < n; i++) do_cycle(0, '0, '0, 0, '0, '0, 0, '0, g0, g1);
  endtask

  initial begin : stim
    bit            g0, g1, p0, p1;
    logic [AW-1:0] pa0, pa1, aa;
    logic [DW-1:0] pd0, pd1;
    bit            av;

    rf_if.req0_val = 0; rf_if.req0_addr = '0; rf_if.req0_data = '0;
    rf_if.req1_val = 0; rf_if.req1_addr = '0; rf_if.req1_data = '0;
    rf_if.alloc_val = 0; rf_if.alloc_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_en", 64'(rf_if.write_en), 64'(0));
    check("rst_write_addr", 64'(rf_if.write_addr), 64'(0));
    check("rst_write_data", 64'(rf_if.write_data), 64'(0));
    check("rst_busy", 64'(rf_if.busy), 64'(0));
    reset = 1'b1;
    idle(1);

    // req0 alone
    do_cycle(1, AW'(3), 32'hDEADBEEF, 0, '0, '0, 0, '0, g0, g1);
    idle(1);
    // req1 to r0: handshake without a write, pointer returns to req0
    do_cycle(0, '0, '0, 1, AW'(0), 32'h0000_1234, 0, '0, g0, g1);
    idle(1);
    // both valid: strict alternation
    for (int i = 0; i < 4; i++)
      do_cycle(1, AW'(1), DW'(32'h100 + i), 1, AW'(2), DW'(32'h200 + i), 0, '0, g0, g1);
    idle(1);
    // req1 stalls behind req0 with stable payload, then wins
    do_cycle(1, AW'(4), 32'hA0A0_0001, 1, AW'(6), 32'h6666_6666, 0, '0, g0, g1);
    do_cycle(1, AW'(4), 32'hA0A0_0002, 1, AW'(6), 32'h6666_6666, 0, '0, g0, g1);
    idle(1);
    // scoreboard: alloc, clear by mul/div write, same-cycle set and clear
    do_cycle(0, '0, '0, 0, '0, '0, 1, AW'(7), g0, g1);
    idle(1);
    do_cycle(0, '0, '0, 1, AW'(7), 32'h7777_0001, 0, '0, g0, g1);
    idle(1);
    do_cycle(0, '0, '0, 1, AW'(7), 32'h7777_0002, 1, AW'(7), g0, g1);
    do_cycle(0, '0, '0, 0, '0, '0, 1, AW'(0), g0, g1);
    idle(1);

    // reset asserted while a req0 write is in flight
    do_cycle(1, AW'(5), 32'h5555_5555, 0, '0, '0, 0, '0, g0, g1);
    reset = 1'b0;
    #1;
    check("midrst_write_en", 64'(rf_if.write_en), 64'(0));
    check("midrst_busy", 64'(rf_if.busy), 64'(0));
    exp_q.delete();
    turn = 0;
    exp_busy = '0;
    last_addr = '0;
    last_data = '0;
    hold_known = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_cycle(1, AW'(8), 32'h8888_0000, 1, AW'(9), 32'h9999_0000, 0, '0, g0, g1);
    idle(1);

    // random traffic; a waiting requester keeps its payload stable
    p0 = 0; p1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0) begin
        p0  = ($urandom_range(0, 9) < 6);
        pa0 = AW'($urandom_range(0, 31));
        pd0 = $urandom;
      end
      if (!p1) begin
        p1  = ($urandom_range(0, 9) < 5);
        pa1 = AW'($urandom_range(0, 7));
        pd1 = $urandom;
      end
      av = ($urandom_range(0, 9) < 3);
      aa = AW'($urandom_range(0, 7));
      do_cycle(p0, pa0, pd0, p1, pa1, pd1, av, aa, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
